// File: rtl/nexys_starship_pkg.sv
// Shared encodings for the starship-monsters game: one-hot game state, lane state,
// and the default attack timeout (one second at 200 MHz).
package nexys_starship_pkg;

   localparam int unsigned DEFAULT_TIMEOUT = 200_000_000;

   typedef enum logic [2:0] {
      StInit = 3'b001,
      StPlay = 3'b010,
      StOver = 3'b100
   } game_state_e;

   typedef enum logic {
      LnEmpty = 1'b0,
      LnFull  = 1'b1
   } lane_state_e;

endpackage

// File: rtl/nexys_starship_lane.sv
// One monster lane: EMPTY/FULL state, attack timer and registered kill pulse.
// The expire flag tells the game FSM that this lane's monster has won.
module nexys_starship_lane
   import nexys_starship_pkg::*;
#(
   parameter int unsigned TIMER_W = 28,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic Clk,
   input  logic Reset,
   input  logic active,
   input  logic clear,
   input  logic spawn,
   input  logic shoot,
   output logic full,
   output logic kill,
   output logic expire
);

   localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(TIMEOUT - 1);

   lane_state_e        state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               kill_q, kill_d;
   logic               timer_zero;

   assign timer_zero = (timer_q == '0);
   assign full       = (state_q == LnFull);
   assign kill       = kill_q;

   // A shot on the final edge beats the timeout.
   assign expire = active & full & timer_zero & ~shoot;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      kill_d  = active & full & shoot;
      if (clear) begin
         state_d = LnEmpty;
         timer_d = '0;
      end else if (active) begin
         unique case (state_q)
            LnEmpty: begin
               if (spawn) begin
                  state_d = LnFull;
                  timer_d = RELOAD;
               end
            end
            LnFull: begin
               if (shoot) begin
                  state_d = LnEmpty;
                  timer_d = '0;
               end else if (!timer_zero) begin
                  timer_d = timer_q - 1'b1;
               end
            end
            default: begin
               state_d = LnEmpty;
               timer_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= LnEmpty;
         timer_q <= '0;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         kill_q  <= kill_d;
      end
   end

endmodule

// File: rtl/nexys_starship_monsters.sv
// Starship-monsters game core: one-hot INIT/PLAY/OVER FSM over NUM_LANES monster lanes.
// Define NEXYS_STARSHIP_SCORE_EN to add the saturating 16-bit score output.
module nexys_starship_monsters
   import nexys_starship_pkg::*;
#(
   parameter int unsigned NUM_LANES = 4,
   parameter int unsigned TIMER_W   = 28,
   parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 play_flag,
   input  logic [NUM_LANES-1:0] spawn_req,
   input  logic [NUM_LANES-1:0] shoot,
   output logic [NUM_LANES-1:0] monster_sm,
   output logic [NUM_LANES-1:0] kill,
   output logic                 game_over,
   output logic                 q_Init,
   output logic                 q_Play,
   output logic                 q_Over
`ifdef NEXYS_STARSHIP_SCORE_EN
   ,
   output logic [15:0]          score
`endif
);

   game_state_e          state_q, state_d;
   logic                 active;
   logic                 clear_lanes;
   logic                 any_expire;
   logic [NUM_LANES-1:0] expire;

   // Lanes only advance while the game is running and the player has not quit.
   assign active      = (state_q == StPlay) & play_flag;
   assign any_expire  = |expire;
   assign clear_lanes = ~active | any_expire;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      nexys_starship_lane #(
         .TIMER_W (TIMER_W),
         .TIMEOUT (TIMEOUT)
      ) u_lane (
         .Clk    (Clk),
         .Reset  (Reset),
         .active (active),
         .clear  (clear_lanes),
         .spawn  (spawn_req[i]),
         .shoot  (shoot[i]),
         .full   (monster_sm[i]),
         .kill   (kill[i]),
         .expire (expire[i])
      );
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StInit: if (play_flag) state_d = StPlay;
         StPlay: begin
            if (!play_flag) begin
               state_d = StInit;
            end else if (any_expire) begin
               state_d = StOver;
            end
         end
         StOver: if (!play_flag) state_d = StInit;
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= StInit;
      end else begin
         state_q <= state_d;
      end
   end

   assign q_Init    = (state_q == StInit);
   assign q_Play    = (state_q == StPlay);
   assign q_Over    = (state_q == StOver);
   assign game_over = q_Over;

`ifdef NEXYS_STARSHIP_SCORE_EN
   logic [15:0] score_q, score_d;
   logic [16:0] kill_cnt;
   logic [16:0] score_sum;

   always_comb begin
      kill_cnt = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         kill_cnt = kill_cnt + 17'(kill[i]);
      end
      score_sum = {1'b0, score_q} + kill_cnt;
      if ((state_q == StInit) && play_flag) begin
         score_d = '0;
      end else if (score_sum > 17'h0FFFF) begin
         score_d = 16'hFFFF;
      end else begin
         score_d = score_sum[15:0];
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         score_q <= '0;
      end else begin
         score_q <= score_d;
      end
   end

   assign score = score_q;
`endif

endmodule

// File: doc/nexys_starship_monsters.md
NEXYS_STARSHIP_MONSTERS -- requirements
Module: nexys_starship_monsters

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 4: number of independent monster lanes (top, bottom, left, right).
REQ-002 The block SHALL have parameter TIMER_W, default 28: width of each lane's attack timer.
REQ-003 The block SHALL have parameter TIMEOUT, default 200_000_000: cycles a monster may stay FULL before the game is lost; legal range 1..2^TIMER_W-1.
REQ-004 The block SHALL have port Clk, input, 1: single system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port play_flag, input, 1: level; high means the game is running.
REQ-007 The block SHALL have port spawn_req, input, NUM_LANES: per-lane spawn request from the random source.
REQ-008 The block SHALL have port shoot, input, NUM_LANES: per-lane player shot, one bit per lane.
REQ-009 The block SHALL have port monster_sm, output, NUM_LANES: registered; bit i high while lane i is FULL.
REQ-010 The block SHALL have port kill, output, NUM_LANES: registered one-cycle pulse per defeated monster.
REQ-011 The block SHALL have port game_over, output, 1: registered; high in OVER.
REQ-012 The block SHALL have ports q_Init, q_Play, q_Over, output, 1 each: one-hot game state.

Function
REQ-013 The game FSM SHALL be one-hot {INIT, PLAY, OVER}; an illegal encoding SHALL go to INIT on the next edge.
REQ-014 In INIT, the FSM SHALL hold all lanes EMPTY and go to PLAY on the edge where play_flag=1.
REQ-015 In PLAY, each lane SHALL run its own EMPTY/FULL FSM, independent of the other lanes.
REQ-016 An EMPTY lane with spawn_req[i]=1 at edge k SHALL show monster_sm[i]=1 after edge k and load its timer with TIMEOUT-1.
REQ-017 A FULL lane SHALL decrement its timer by 1 on every edge, with no wrap below 0.
REQ-018 A FULL lane with shoot[i]=1 SHALL go EMPTY on that edge and pulse kill[i] for exactly one cycle.
REQ-019 A FULL lane with timer=0 and shoot[i]=0 SHALL move the game FSM to OVER; monster_sm[i] is therefore high for exactly TIMEOUT cycles before game_over rises.
REQ-020 If shoot[i] and timer=0 occur on the same edge, the shot SHALL win: the lane goes EMPTY and no OVER results.
REQ-021 The lane FSM SHALL ignore spawn_req[i] while FULL and shoot[i] while EMPTY; kill SHALL NOT pulse for a shot at an EMPTY lane.
REQ-022 Several lanes timing out on the same edge SHALL give a single transition to OVER.
REQ-023 In OVER, the block SHALL clear all lanes, hold game_over=1, and go to INIT on the first edge with play_flag=0.
REQ-024 If play_flag falls during PLAY, the FSM SHALL go to INIT, clear all lanes, and leave game_over at 0.

Reset
REQ-025 Reset SHALL immediately force INIT, with monster_sm=0, kill=0, game_over=0, all timers 0 and score 0, including when asserted mid-game.

Configuration
REQ-026 With NEXYS_STARSHIP_SCORE_EN defined, the block SHALL add output score[15:0], which adds the popcount of kill each cycle, saturates at 16'hFFFF, and clears on entry to PLAY from INIT.
REQ-027 Without NEXYS_STARSHIP_SCORE_EN, the score port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-028 Package nexys_starship_pkg SHALL hold the game-state and lane-state encodings and the default TIMEOUT constant.
REQ-029 The per-lane FSM, timer and kill pulse SHALL be in sub-module nexys_starship_lane, instantiated NUM_LANES times with a generate loop.

Verification (TIMEOUT=8, NUM_LANES=4)
REQ-030 Test: reset, play_flag=1, spawn_req=4'b0001 for one cycle -> monster_sm=4'b0001 for exactly 8 cycles, then game_over=1 and q_Over=1.
REQ-031 Test: spawn lane 2, shoot[2] 3 cycles later -> kill=4'b0100 for one cycle, monster_sm[2]=0, and with the macro on, score=1.
REQ-032 Test: shoot[1] on the same edge that lane 1's timer=0 -> kill[1] pulses and game_over stays 0.
REQ-033 Test: spawn_req=4'b1111 together, shoot 4'b1111 together -> kill=4'b1111 for one cycle, and score increments by 4.
REQ-034 Test: Reset asserted mid-game with 3 lanes FULL -> all outputs 0 and q_Init=1 before the next Clk edge.
REQ-035 Test: in OVER, drop play_flag -> INIT on the next edge; raise play_flag -> PLAY with score=0.
